pmod_status_unit: RTL and testbench

Drives the PMOD RGB status LED and buzzer from the system status flags. Successor to the single-pulse LED driver, with these additions:
- programmable-brightness PWM,
- an error state with a blinking red LED,
- an event-driven buzzer sequencer that plays short, double and long beep patterns.

It sits beside the command/control FSM. All inputs are level flags from that FSM.

---
 rtl/pmod_pkg.sv | 45 ++++
 rtl/pmod_status_unit_pwm_gen.sv | 53 +++++
 rtl/pmod_status_unit.sv | 197 +++++++++++++++++++
 tb/tb_pmod_status_unit.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmod_pkg.sv
// Shared types, default tick constants and colour codes for the PMOD status
// LED / buzzer unit.
package pmod_pkg;

    typedef enum logic [1:0] {
        BZ_IDLE = 2'd0,
        BZ_ON1  = 2'd1,
        BZ_GAP  = 2'd2,
        BZ_ON2  = 2'd3
    } bz_state_e;

    localparam int DEFAULT_BLINK_TICKS      = 32'd25000000;
    localparam int DEFAULT_BEEP_SHORT_TICKS = 32'd2000000;
    localparam int DEFAULT_BEEP_LONG_TICKS  = 32'd30000000;
    localparam int DEFAULT_BEEP_GAP_TICKS   = 32'd2000000;

    // Colour code bit order is {red, green, blue}.
    localparam logic [2:0] COL_OFF = 3'b000;
    localparam logic [2:0] COL_RED = 3'b100;
    localparam logic [2:0] COL_GRN = 3'b010;
    localparam logic [2:0] COL_BLU = 3'b001;
    localparam logic [2:0] COL_YEL = 3'b110;

    function automatic logic [2:0] colour_select(
        input logic error,
        input logic init_done,
        input logic idle,
        input logic wait_cmd
    );
        logic [2:0] col;
        if (error) begin
            col = COL_RED;
        end else if (!init_done) begin
            col = COL_RED;
        end else if (idle && wait_cmd) begin
            col = COL_YEL;
        end else if (idle) begin
            col = COL_GRN;
        end else begin
            col = COL_BLU;
        end
        return col;
    endfunction

endpackage

// File: rtl/pmod_status_unit_pwm_gen.sv
// Frame-based PWM generator; the duty value is latched once per frame so a
// brightness change never produces a glitched partial frame.
module pmod_pwm_gen #(
    parameter int PWM_PERIOD = 64,
    parameter int PWM_W      = 6
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [PWM_W-1:0] i_duty,
    output logic             o_pwm,
    output logic             o_frame_wrap
);

    localparam logic [PWM_W-1:0] CNT_LAST = PWM_W'(PWM_PERIOD - 1);

    logic [PWM_W-1:0] cnt_q, cnt_d;
    logic [PWM_W-1:0] duty_q, duty_d;
    logic             load_q, load_d;
    logic             wrap_s;

    // load_q is set only in the first cycle after reset release so the
    // requested brightness is picked up without waiting for a frame wrap.
    always_comb begin
        wrap_s = (cnt_q == CNT_LAST);
        if (wrap_s) begin
            cnt_d = {PWM_W{1'b0}};
        end else begin
            cnt_d = cnt_q + PWM_W'(1);
        end
        if (wrap_s || load_q) begin
            duty_d = i_duty;
        end else begin
            duty_d = duty_q;
        end
        load_d = 1'b0;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            cnt_q  <= {PWM_W{1'b0}};
            duty_q <= {PWM_W{1'b0}};
            load_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
            load_q <= load_d;
        end
    end

    assign o_pwm        = (cnt_q < duty_q);
    assign o_frame_wrap = wrap_s;

endmodule

// File: rtl/pmod_status_unit.sv
// PMOD RGB status LED and buzzer driver: PWM brightness, error blink, and an
// edge-triggered short / double / long beep sequencer.
module pmod_status_unit
    import pmod_pkg::*;
#(
    parameter int PWM_PERIOD       = 64,
    parameter int PWM_W            = 6,
    parameter int BLINK_TICKS      = DEFAULT_BLINK_TICKS,
    parameter int BEEP_SHORT_TICKS = DEFAULT_BEEP_SHORT_TICKS,
    parameter int BEEP_LONG_TICKS  = DEFAULT_BEEP_LONG_TICKS,
    parameter int BEEP_GAP_TICKS   = DEFAULT_BEEP_GAP_TICKS,
    parameter int CNT_W            = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [PWM_W-1:0] i_brightness,
    input  logic             i_init_done,
    input  logic             i_idle,
    input  logic             i_wait_cmd,
    input  logic             i_cmd_valid,
    input  logic             i_error,
    output logic             o_led_r,
    output logic             o_led_g,
    output logic             o_led_b,
    output logic             o_buzzer,
    output logic             o_buzzer_busy
);

    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_TICKS - 1);
    localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(BEEP_SHORT_TICKS - 1);
    localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(BEEP_LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(BEEP_GAP_TICKS - 1);

    logic pwm_s;
    logic frame_wrap_s;

    pmod_pwm_gen #(
        .PWM_PERIOD (PWM_PERIOD),
        .PWM_W      (PWM_W)
    ) u_pwm_gen (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_duty       (i_brightness),
        .o_pwm        (pwm_s),
        .o_frame_wrap (frame_wrap_s)
    );

    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_ph_q, blink_ph_d;
    logic             led_r_q, led_r_d, led_g_q, led_g_d, led_b_q, led_b_d;
    logic             cmd_q, cmd_d, err_q, err_d, init_q, init_d;
    logic             arm_q, arm_d;
    logic             ev_short_s, ev_long_s, ev_double_s;
    bz_state_e        state_q, state_d;
    logic             long_q, long_d, dbl_q, dbl_d;
    logic [CNT_W-1:0] beep_cnt_q, beep_cnt_d;
    logic [CNT_W-1:0] len_last_s;
    logic             buzzer_q, buzzer_d, busy_q, busy_d;
    logic [2:0]       col_s;
    logic             lit_s;

    // Free-running error blink phase.
    always_comb begin
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = {CNT_W{1'b0}};
            blink_ph_d  = ~blink_ph_q;
        end else begin
            blink_cnt_d = blink_cnt_q + CNT_W'(1);
            blink_ph_d  = blink_ph_q;
        end
    end

    // LED colour selection, registered one cycle before the pins.
    always_comb begin
        col_s = colour_select(i_error, i_init_done, i_idle, i_wait_cmd);
        lit_s = i_error ? (pwm_s & blink_ph_q) : pwm_s;
        {led_r_d, led_g_d, led_b_d} = col_s & {3{lit_s}};
    end

    // arm_q masks the first cycle after reset so flags already high at
    // release are absorbed into the edge registers instead of firing.
    always_comb begin
        cmd_d       = i_cmd_valid;
        err_d       = i_error;
        init_d      = i_init_done;
        arm_d       = 1'b1;
        ev_short_s  = arm_q & i_cmd_valid & ~cmd_q;
        ev_long_s   = arm_q & i_error & ~err_q;
        ev_double_s = arm_q & i_init_done & ~init_q;
    end

    // Buzzer sequencer; a long beep preempts anything in flight.
    always_comb begin
        state_d    = state_q;
        long_d     = long_q;
        dbl_d      = dbl_q;
        beep_cnt_d = beep_cnt_q + CNT_W'(1);
        len_last_s = long_q ? LONG_LAST : SHORT_LAST;
        if (ev_long_s) begin
            state_d    = BZ_ON1;
            long_d     = 1'b1;
            dbl_d      = 1'b0;
            beep_cnt_d = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                BZ_IDLE: begin
                    beep_cnt_d = {CNT_W{1'b0}};
                    if (ev_double_s) begin
                        state_d = BZ_ON1;
                        long_d  = 1'b0;
                        dbl_d   = 1'b1;
                    end else if (ev_short_s) begin
                        state_d = BZ_ON1;
                        long_d  = 1'b0;
                        dbl_d   = 1'b0;
                    end else begin
                        state_d = BZ_IDLE;
                    end
                end
                BZ_ON1: begin
                    if (beep_cnt_q == len_last_s) begin
                        beep_cnt_d = {CNT_W{1'b0}};
                        state_d    = dbl_q ? BZ_GAP : BZ_IDLE;
                    end else begin
                        state_d = BZ_ON1;
                    end
                end
                BZ_GAP: begin
                    if (beep_cnt_q == GAP_LAST) begin
                        beep_cnt_d = {CNT_W{1'b0}};
                        state_d    = BZ_ON2;
                    end else begin
                        state_d = BZ_GAP;
                    end
                end
                BZ_ON2: begin
                    if (beep_cnt_q == SHORT_LAST) begin
                        beep_cnt_d = {CNT_W{1'b0}};
                        state_d    = BZ_IDLE;
                    end else begin
                        state_d = BZ_ON2;
                    end
                end
                default: begin
                    state_d    = BZ_IDLE;
                    beep_cnt_d = {CNT_W{1'b0}};
                end
            endcase
        end
        buzzer_d = (state_d == BZ_ON1) || (state_d == BZ_ON2);
        busy_d   = (state_d != BZ_IDLE);
    end

    // All state and output registers.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            blink_cnt_q <= {CNT_W{1'b0}};
            blink_ph_q  <= 1'b0;
            led_r_q     <= 1'b0;
            led_g_q     <= 1'b0;
            led_b_q     <= 1'b0;
            cmd_q       <= 1'b0;
            err_q       <= 1'b0;
            init_q      <= 1'b0;
            arm_q       <= 1'b0;
            state_q     <= BZ_IDLE;
            long_q      <= 1'b0;
            dbl_q       <= 1'b0;
            beep_cnt_q  <= {CNT_W{1'b0}};
            buzzer_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            led_r_q     <= led_r_d;
            led_g_q     <= led_g_d;
            led_b_q     <= led_b_d;
            cmd_q       <= cmd_d;
            err_q       <= err_d;
            init_q      <= init_d;
            arm_q       <= arm_d;
            state_q     <= state_d;
            long_q      <= long_d;
            dbl_q       <= dbl_d;
            beep_cnt_q  <= beep_cnt_d;
            buzzer_q    <= buzzer_d;
            busy_q      <= busy_d;
        end
    end

    assign o_led_r       = led_r_q;
    assign o_led_g       = led_g_q;
    assign o_led_b       = led_b_q;
    assign o_buzzer      = buzzer_q;
    assign o_buzzer_busy = busy_q;

endmodule

// File: tb/tb_pmod_status_unit.sv
// Scoreboard bench for pmod_status_unit: expected {r,g,b,buzzer,busy} words are
// queued with the stimulus and compared on the falling clock edge.
module tb_pmod_status_unit;

    localparam int PP = 8;
    localparam int PW = 4;
    localparam int BT = 20;
    localparam logic [4:0] M_LED = 5'b11100;
    localparam logic [4:0] M_BZ  = 5'b00011;
    localparam logic [4:0] M_ALL = 5'b11111;
    localparam logic [4:0] C_RED = 5'b10000;
    localparam logic [4:0] C_GRN = 5'b01000;
    localparam logic [4:0] C_BLU = 5'b00100;
    localparam logic [4:0] C_YEL = 5'b11000;
    localparam logic [4:0] BZ_ON = 5'b00011;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [PW-1:0] i_brightness = 4'd0;
    logic          i_init_done = 1'b0, i_idle = 1'b0, i_wait_cmd = 1'b0;
    logic          i_cmd_valid = 1'b0, i_error = 1'b0;
    logic          o_led_r, o_led_g, o_led_b, o_buzzer, o_buzzer_busy;
    logic [4:0]    obs_s;

    int n_vec = 0;
    int n_bad = 0;
    int tick;
    logic [4:0] sb_q[$];
    logic [4:0] sbm_q[$];

    pmod_status_unit #(
        .PWM_PERIOD(PP), .PWM_W(PW), .BLINK_TICKS(BT),
        .BEEP_SHORT_TICKS(5), .BEEP_LONG_TICKS(12), .BEEP_GAP_TICKS(3), .CNT_W(32)
    ) dut (
        .i_clock(clk), .i_reset(rst), .i_brightness(i_brightness),
        .i_init_done(i_init_done), .i_idle(i_idle), .i_wait_cmd(i_wait_cmd),
        .i_cmd_valid(i_cmd_valid), .i_error(i_error),
        .o_led_r(o_led_r), .o_led_g(o_led_g), .o_led_b(o_led_b),
        .o_buzzer(o_buzzer), .o_buzzer_busy(o_buzzer_busy)
    );

    assign obs_s = {o_led_r, o_led_g, o_led_b, o_buzzer, o_buzzer_busy};

    always #5 clk = ~clk;

    // Rising edges since reset release; the PWM and blink counters start at 0 then.
    always @(posedge clk or posedge rst) begin
        if (rst) tick <= 0;
        else     tick <= tick + 1;
    end

    task automatic push(input logic [4:0] v, input logic [4:0] m);
        sb_q.push_back(v);
        sbm_q.push_back(m);
    endtask

    task automatic push_frame(input int duty, input logic [4:0] col);
        for (int p = 0; p < PP; p++) push((p < duty) ? col : 5'b00000, M_LED);
    endtask

    // Returns with the next sample being PWM counter 0 of a frame using duty b.
    task automatic align(input logic [PW-1:0] b);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 2 * PP; k++) begin
            @(negedge clk);
            if (((tick - 1) % PP) == PP - 2) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) begin
            n_vec++;
            n_bad++;
            $display("FAIL align: frame phase not found within %0d cycles", 2 * PP);
        end
        i_brightness = b;
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic [4:0] e, m;
        int idx;
        #1 rst = 1'b1;
        repeat (3) push(5'b00000, M_ALL);
        idx = 0;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            e = sb_q.pop_front(); m = sbm_q.pop_front(); n_vec++;
            if ((obs_s & m) !== (e & m)) begin
                n_bad++;
                $display("FAIL reset idx=%0d got=%b want=%b mask=%b", idx, obs_s, e, m);
            end
            idx++;
        end
        rst = 1'b0;
    endtask

    task automatic test_colour_red;
        logic [4:0] e, m;
        int idx;
        i_init_done = 1'b0; i_idle = 1'b0; i_wait_cmd = 1'b0; i_error = 1'b0;
        align(4'd3);
        push_frame(3, C_RED); push_frame(3, C_RED);
        idx = 0;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            e = sb_q.pop_front(); m = sbm_q.pop_front(); n_vec++;
            if ((obs_s & m) !== (e & m)) begin
                n_bad++;
                $display("FAIL colour_red idx=%0d got=%b want=%b mask=%b", idx, obs_s, e, m);
            end
            idx++;
        end
    endtask

    task automatic test_double;
        logic [4:0] e, m;
        int idx;
        i_init_done = 1'b1;
        for (int i = 0; i < 18; i++)
            push({3'b000, (i < 5) || (i >= 8 && i < 13), i < 13}, M_BZ);
        idx = 0;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            e = sb_q.pop_front(); m = sbm_q.pop_front(); n_vec++;
            if ((obs_s & m) !== (e & m)) begin
                n_bad++;
                $display("FAIL double idx=%0d got=%b want=%b mask=%b", idx, obs_s, e, m);
            end
            if (idx == 5) i_cmd_valid = 1'b1;
            idx++;
        end
    endtask

    task automatic test_pwm;
        logic [4:0] e, m;
        int idx;
        int duties[4] = '{3, 0, 8, 15};
        i_cmd_valid = 1'b0; i_init_done = 1'b1; i_idle = 1'b1; i_wait_cmd = 1'b0;
        for (int d = 0; d < 4; d++) begin
            align(PW'(duties[d]));
            push_frame(duties[d], C_GRN); push_frame(duties[d], C_GRN);
            idx = 0;
            while (sb_q.size() > 0) begin
                @(negedge clk);
                e = sb_q.pop_front(); m = sbm_q.pop_front(); n_vec++;
                if ((obs_s & m) !== (e & m)) begin
                    n_bad++;
                    $display("FAIL pwm duty=%0d idx=%0d got=%b want=%b", duties[d], idx, obs_s, e);
                end
                idx++;
            end
        end
        align(4'd3);
        push_frame(3, C_GRN); push_frame(3, C_GRN);
        push_frame(6, C_GRN); push_frame(6, C_GRN);
        idx = 0;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            e = sb_q.pop_front(); m = sbm_q.pop_front(); n_vec++;
            if ((obs_s & m) !== (e & m)) begin
                n_bad++;
                $display("FAIL pwm_midframe idx=%0d got=%b want=%b", idx, obs_s, e);
            end
            if (idx == 10) i_brightness = 4'd6;
            idx++;
        end
    endtask

    task automatic test_colour_mix;
        logic [4:0] e, m;
        int idx;
        int t0;
        i_idle = 1'b1; i_wait_cmd = 1'b1;
        align(4'd3);
        push_frame(3, C_YEL); push_frame(3, C_YEL);
        idx = 0;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            e = sb_q.pop_front(); m = sbm_q.pop_front(); n_vec++;
            if ((obs_s & m) !== (e & m)) begin
                n_bad++;
                $display("FAIL colour_yellow idx=%0d got=%b want=%b", idx, obs_s, e);
            end
            idx++;
        end
        i_idle = 1'b0; i_wait_cmd = 1'b0;
        align(4'd3);
        push_frame(3, C_BLU); push_frame(3, C_BLU);
        idx = 0;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            e = sb_q.pop_front(); m = sbm_q.pop_front(); n_vec++;
            if ((obs_s & m) !== (e & m)) begin
                n_bad++;
                $display("FAIL colour_blue idx=%0d got=%b want=%b", idx, obs_s, e);
            end
            idx++;
        end
        align(4'd8);
        i_error = 1'b1;
        t0 = tick;
        for (int i = 0; i < 3 * BT; i++)
            push((((t0 + i) / BT) % 2 == 1) ? C_RED : 5'b00000, M_LED);
        idx = 0;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            e = sb_q.pop_front(); m = sbm_q.pop_front(); n_vec++;
            if ((obs_s & m) !== (e & m)) begin
                n_bad++;
                $display("FAIL error_blink idx=%0d got=%b want=%b", idx, obs_s, e);
            end
            idx++;
        end
        i_error = 1'b0;
    endtask

    task automatic test_short;
        logic [4:0] e, m;
        int idx;
        i_cmd_valid = 1'b0; i_error = 1'b0;
        repeat (15) @(negedge clk);
        i_cmd_valid = 1'b1;
        for (int i = 0; i < 15; i++) push((i < 5) ? BZ_ON : 5'b00000, M_BZ);
        idx = 0;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            e = sb_q.pop_front(); m = sbm_q.pop_front(); n_vec++;
            if ((obs_s & m) !== (e & m)) begin
                n_bad++;
                $display("FAIL short idx=%0d got=%b want=%b", idx, obs_s, e);
            end
            idx++;
        end
    endtask

    task automatic test_preempt;
        logic [4:0] e, m;
        int idx;
        i_cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        i_cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) push((i < 14) ? BZ_ON : 5'b00000, M_BZ);
        idx = 0;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            e = sb_q.pop_front(); m = sbm_q.pop_front(); n_vec++;
            if ((obs_s & m) !== (e & m)) begin
                n_bad++;
                $display("FAIL preempt idx=%0d got=%b want=%b", idx, obs_s, e);
            end
            if (idx == 1) i_error = 1'b1;
            idx++;
        end
        i_cmd_valid = 1'b0; i_error = 1'b0;
        repeat (3) @(negedge clk);
        i_cmd_valid = 1'b1; i_error = 1'b1;
        for (int i = 0; i < 18; i++) push((i < 12) ? BZ_ON : 5'b00000, M_BZ);
        idx = 0;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            e = sb_q.pop_front(); m = sbm_q.pop_front(); n_vec++;
            if ((obs_s & m) !== (e & m)) begin
                n_bad++;
                $display("FAIL same_cycle idx=%0d got=%b want=%b", idx, obs_s, e);
            end
            idx++;
        end
    endtask

    task automatic test_reset_mid;
        logic [4:0] e, m;
        int idx;
        i_cmd_valid = 1'b0; i_error = 1'b0; i_brightness = 4'd15;
        repeat (3) @(negedge clk);
        i_error = 1'b1;
        repeat (4) push(BZ_ON, M_BZ);
        idx = 0;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            e = sb_q.pop_front(); m = sbm_q.pop_front(); n_vec++;
            if ((obs_s & m) !== (e & m)) begin
                n_bad++;
                $display("FAIL reset_mid_pre idx=%0d got=%b want=%b", idx, obs_s, e);
            end
            idx++;
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (obs_s !== 5'b00000) begin
            n_bad++;
            $display("FAIL reset_mid_async got=%b want=%b", obs_s, 5'b00000);
        end
        i_cmd_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) push(5'b00000, M_BZ);
        idx = 0;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            e = sb_q.pop_front(); m = sbm_q.pop_front(); n_vec++;
            if ((obs_s & m) !== (e & m)) begin
                n_bad++;
                $display("FAIL reset_release idx=%0d got=%b want=%b", idx, obs_s, e);
            end
            idx++;
        end
        i_cmd_valid = 1'b0;
        @(negedge clk);
        i_cmd_valid = 1'b1;
        for (int i = 0; i < 8; i++) push((i < 5) ? BZ_ON : 5'b00000, M_BZ);
        idx = 0;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            e = sb_q.pop_front(); m = sbm_q.pop_front(); n_vec++;
            if ((obs_s & m) !== (e & m)) begin
                n_bad++;
                $display("FAIL reset_new_edge idx=%0d got=%b want=%b", idx, obs_s, e);
            end
            idx++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit (%0d vectors, %0d miscompares)", n_vec, n_bad);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_colour_red();
        test_double();
        test_pwm();
        test_colour_mix();
        test_short();
        test_preempt();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
